// File: rtl/fetch_unit.sv
// Instruction-fetch / next-PC stage: owns the architectural PC, reads instruction memory
// over req/gnt/rvalid, holds one instruction for decode and redirects on jumps and branches.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic [1:0]      pc_sel,
    input  logic            jump,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    output logic            trap_misaligned,
    output logic [XLEN-1:0] trap_pc
);

    typedef enum logic [1:0] {FETCH, WAIT, VALID, TRAP} state_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic            data_arrives;
    logic            accept;
    logic            misaligned;

    assign data_arrives = ((state == FETCH) && imem_gnt && imem_rvalid) ||
                          ((state == WAIT) && imem_rvalid);
    assign accept       = (state == VALID) && instr_ready;
    assign misaligned   = (next_pc[1:0] != 2'b00);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_pc = pc + XLEN'(4);
        if (jump) begin
            unique case (pc_sel)
                2'b00: next_pc = pc + XLEN'(4);
                2'b01: next_pc = pc + imm;
                2'b10: next_pc = (rs1_data + imm) & {{(XLEN-1){1'b1}}, 1'b0};
                2'b11: next_pc = branch_taken ? pc + imm : pc + XLEN'(4);
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            FETCH: if (imem_gnt) state_next = imem_rvalid ? VALID : WAIT;
            WAIT:  if (imem_rvalid) state_next = VALID;
            VALID: if (instr_ready) state_next = misaligned ? TRAP : FETCH;
            TRAP:  state_next = TRAP;
        endcase
    end

    // The request is masked by rst so it cannot glitch high while reset is held.
    always_comb begin
        imem_req    = (state == FETCH) && !rst;
        instr_valid = (state == VALID);
    end

    // NOTE: only control and architectural registers are reset; there is no memory array here to clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc              <= RESET_PC;
            instr_o         <= '0;
            trap_misaligned <= 1'b0;
            trap_pc         <= '0;
        end else begin
            if (data_arrives) instr_o <= imem_rdata;
            if (accept) begin
                if (misaligned) begin
                    trap_misaligned <= 1'b1;
                    trap_pc         <= next_pc;
                end else begin
                    pc <= next_pc;
                end
            end
        end
    end

    assign imem_addr = pc;
    assign pc_o      = pc;

endmodule
